// File: rtl/external_bus_interface.sv
// -----------------------------------------------------------------------------
// external_bus_interface
//
// Registered bus interface between the CPU internal dataflow and external
// memory. A request seen in IDLE captures the address, write byte and
// direction, then one memory access runs with a memAck handshake and any
// number of wait states. Read data is latched and handed back to the core.
// A one-cycle cpuReady strobe marks completion.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : a wait counter forces completion after TIMEOUT_CYCLES access
//               cycles without memAck. Forced reads return TIMEOUT_DATA and
//               set the sticky busError flag.
//   undefined : ACCESS waits indefinitely for memAck, and busError is 0.
//
// Ports:
//   clk, nrst             clock (rising edge), async active-low reset
//   cpuAddrLow/High [7:0] address bytes from the core
//   cpuWriteData    [7:0] write byte from the core
//   cpuReadNotWrite       1 = read, 0 = write
//   cpuCycleRequest       access request, sampled only in IDLE
//   cpuReadData     [7:0] last completed read byte
//   cpuReady              one-cycle completion strobe
//   memAddress     [15:0] registered {high, low} address
//   memWriteData    [7:0] registered write byte
//   memReadEnable         read strobe, held for the whole access
//   memWriteEnable        write strobe, held for the whole access
//   memAck                memory completes the access
//   memReadData     [7:0] memory read byte, valid with memAck
//   busError              sticky timeout indicator
// -----------------------------------------------------------------------------
module external_bus_interface #(
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [7:0] TIMEOUT_DATA   = 8'hFF
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  cpuAddrLow,
    input  logic [7:0]  cpuAddrHigh,
    input  logic [7:0]  cpuWriteData,
    input  logic        cpuReadNotWrite,
    input  logic        cpuCycleRequest,
    output logic [7:0]  cpuReadData,
    output logic        cpuReady,
    output logic [15:0] memAddress,
    output logic [7:0]  memWriteData,
    output logic        memReadEnable,
    output logic        memWriteEnable,
    input  logic        memAck,
    input  logic [7:0]  memReadData,
    output logic        busError
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        is_read_q, is_read_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic        ready_q, ready_d;

`ifdef BUS_TIMEOUT_EN
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
`endif

    // All state resets asynchronously, so an access in flight drops its
    // enables the moment nrst falls and never produces a cpuReady.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_read_q  <= 1'b0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            ready_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            is_read_q  <= is_read_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            ready_q    <= ready_d;
`ifdef BUS_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        is_read_d  = is_read_q;
        ren_d      = ren_q;
        wen_d      = wen_q;
        ready_d    = 1'b0;
`ifdef BUS_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                // memAck is deliberately ignored here; only a request matters.
                if (cpuCycleRequest) begin
                    addr_d     = {cpuAddrHigh, cpuAddrLow};
                    wdata_d    = cpuWriteData;
                    is_read_d  = cpuReadNotWrite;
                    ren_d      = cpuReadNotWrite;
                    wen_d      = ~cpuReadNotWrite;
                    state_d    = ACCESS;
`ifdef BUS_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end

            ACCESS: begin
                // memAck takes priority over the timeout when both coincide.
                if (memAck) begin
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                    if (is_read_q) begin
                        rdata_d = memReadData;
                    end
`ifdef BUS_TIMEOUT_EN
                end else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                    if (is_read_q) begin
                        rdata_d = TIMEOUT_DATA;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign cpuReadData    = rdata_q;
    assign cpuReady       = ready_q;
    assign memAddress     = addr_q;
    assign memWriteData   = wdata_q;
    assign memReadEnable  = ren_q;
    assign memWriteEnable = wen_q;

`ifdef BUS_TIMEOUT_EN
    assign busError = err_q;
`else
    // The timeout parameters have no function without the counter.
    logic [15:0] unused_timeout_cfg;
    assign unused_timeout_cfg = {TIMEOUT_DATA, 8'(TIMEOUT_CYCLES)};
    assign busError = 1'b0;
`endif

endmodule

// File: tb/tb_external_bus_interface.sv
// -----------------------------------------------------------------------------
// tb_external_bus_interface
//
// Self-checking bench for external_bus_interface. A transaction-level model
// tracks the address/write byte last accepted, the last completed read byte
// and the sticky error flag; per-cycle expectations follow from the access
// timing: enables high for k+1 cycles after the request, cpuReady in the
// cycle after memAck.
// -----------------------------------------------------------------------------
module tb_external_bus_interface;

    localparam int         TO_CYCLES = 4;
    localparam logic [7:0] TO_DATA   = 8'hFF;

    logic        clk;
    logic        nrst;
    logic [7:0]  cpuAddrLow;
    logic [7:0]  cpuAddrHigh;
    logic [7:0]  cpuWriteData;
    logic        cpuReadNotWrite;
    logic        cpuCycleRequest;
    logic [7:0]  cpuReadData;
    logic        cpuReady;
    logic [15:0] memAddress;
    logic [7:0]  memWriteData;
    logic        memReadEnable;
    logic        memWriteEnable;
    logic        memAck;
    logic [7:0]  memReadData;
    logic        busError;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;
    logic        m_err;

    external_bus_interface #(
        .TIMEOUT_CYCLES (TO_CYCLES),
        .TIMEOUT_DATA   (TO_DATA)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .cpuAddrLow      (cpuAddrLow),
        .cpuAddrHigh     (cpuAddrHigh),
        .cpuWriteData    (cpuWriteData),
        .cpuReadNotWrite (cpuReadNotWrite),
        .cpuCycleRequest (cpuCycleRequest),
        .cpuReadData     (cpuReadData),
        .cpuReady        (cpuReady),
        .memAddress      (memAddress),
        .memWriteData    (memWriteData),
        .memReadEnable   (memReadEnable),
        .memWriteEnable  (memWriteEnable),
        .memAck          (memAck),
        .memReadData     (memReadData),
        .busError        (busError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_err   = 1'b0;
    endtask

    // Idle cycles with memAck noise; nothing may change.
    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cpuCycleRequest = 1'b0;
            cpuReadNotWrite = 1'($urandom_range(0, 1));
            cpuAddrLow      = 8'($urandom);
            cpuAddrHigh     = 8'($urandom);
            cpuWriteData    = 8'($urandom);
            memAck          = 1'($urandom_range(0, 1));
            memReadData     = 8'($urandom);
            tick();
            checks++;
            if ({cpuReady, memReadEnable, memWriteEnable} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL %s_idle_strobes cyc=%0d got rdy/ren/wen=%b%b%b required 000",
                         tag, i, cpuReady, memReadEnable, memWriteEnable);
            end
            checks++;
            if (memAddress !== m_addr || memWriteData !== m_wdata) begin
                errors++;
                $display("[TB] FAIL %s_idle_hold cyc=%0d got addr=%h wd=%h required addr=%h wd=%h",
                         tag, i, memAddress, memWriteData, m_addr, m_wdata);
            end
            checks++;
            if (cpuReadData !== m_rdata || busError !== m_err) begin
                errors++;
                $display("[TB] FAIL %s_idle_rdata cyc=%0d got rd=%h err=%b required rd=%h err=%b",
                         tag, i, cpuReadData, busError, m_rdata, m_err);
            end
        end
        memAck = 1'b0;
    endtask

    // One access with k wait states; memAck arrives in access cycle k+1.
    // Ends in the cpuReady cycle so a follow-on request can be back-to-back.
    task automatic do_access(input logic rnw, input logic [15:0] addr,
                             input logic [7:0] wd, input int k,
                             input logic [7:0] rd, input string tag);
        cpuCycleRequest = 1'b1;
        cpuReadNotWrite = rnw;
        cpuAddrHigh     = addr[15:8];
        cpuAddrLow      = addr[7:0];
        cpuWriteData    = wd;
        memAck          = 1'($urandom_range(0, 1));
        memReadData     = 8'($urandom);
        tick();
        m_addr  = addr;
        m_wdata = wd;
        for (int j = 0; j <= k; j++) begin
            checks++;
            if (memReadEnable !== rnw || memWriteEnable !== ~rnw) begin
                errors++;
                $display("[TB] FAIL %s_enables cyc=%0d got ren/wen=%b%b required %b%b",
                         tag, j, memReadEnable, memWriteEnable, rnw, ~rnw);
            end
            checks++;
            if (memAddress !== m_addr || memWriteData !== m_wdata) begin
                errors++;
                $display("[TB] FAIL %s_addr cyc=%0d got addr=%h wd=%h required addr=%h wd=%h",
                         tag, j, memAddress, memWriteData, m_addr, m_wdata);
            end
            checks++;
            if (cpuReady !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s_early_ready cyc=%0d got %b required 0", tag, j, cpuReady);
            end
            // Core-side inputs are ignored during the access.
            cpuCycleRequest = 1'($urandom_range(0, 1));
            cpuReadNotWrite = 1'($urandom_range(0, 1));
            cpuAddrLow      = 8'($urandom);
            cpuAddrHigh     = 8'($urandom);
            cpuWriteData    = 8'($urandom);
            memAck          = (j == k);
            memReadData     = (j == k) ? rd : 8'($urandom);
            tick();
        end
        memAck          = 1'b0;
        cpuCycleRequest = 1'b0;
        if (rnw) m_rdata = rd;
        checks++;
        if (cpuReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_ready got %b required 1", tag, cpuReady);
        end
        checks++;
        if (memReadEnable !== 1'b0 || memWriteEnable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_enables_drop got ren/wen=%b%b required 00",
                     tag, memReadEnable, memWriteEnable);
        end
        checks++;
        if (cpuReadData !== m_rdata || busError !== m_err) begin
            errors++;
            $display("[TB] FAIL %s_rdata got rd=%h err=%b required rd=%h err=%b",
                     tag, cpuReadData, busError, m_rdata, m_err);
        end
    endtask

    task automatic test_reset;
        nrst            = 1'b0;
        cpuCycleRequest = 1'b0;
        cpuReadNotWrite = 1'b0;
        cpuAddrLow      = '0;
        cpuAddrHigh     = '0;
        cpuWriteData    = '0;
        memAck          = 1'b0;
        memReadData     = '0;
        model_reset();
        tick();
        tick();
        checks++;
        if ({cpuReadData, cpuReady, memAddress, memWriteData, memReadEnable,
             memWriteEnable, busError} !== 37'd0) begin
            errors++;
            $display("[TB] FAIL reset_values got rd=%h rdy=%b addr=%h wd=%h ren=%b wen=%b err=%b required all 0",
                     cpuReadData, cpuReady, memAddress, memWriteData,
                     memReadEnable, memWriteEnable, busError);
        end
        nrst = 1'b1;
        idle_cycles(10, "reset");
    endtask

    task automatic test_read;
        do_access(1'b1, 16'h12F0, 8'h00, 0, 8'hA5, "read");
        idle_cycles(1, "read");
    endtask

    task automatic test_write_wait;
        do_access(1'b0, 16'h01FF, 8'h3C, 3, 8'h00, "write");
        idle_cycles(1, "write");
    endtask

    task automatic test_back_to_back;
        do_access(1'b1, 16'h4000, 8'h00, 0, 8'h11, "b2b1");
        do_access(1'b1, 16'h4001, 8'h00, 0, 8'h22, "b2b2");
        idle_cycles(2, "b2b");
    endtask

    task automatic test_random;
        for (int t = 0; t < 30; t++) begin
            do_access(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                      int'($urandom_range(0, TO_CYCLES - 1)), 8'($urandom), "rand");
            idle_cycles(int'($urandom_range(0, 2)), "rand");
        end
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout;
        cpuCycleRequest = 1'b1;
        cpuReadNotWrite = 1'b1;
        cpuAddrHigh     = 8'hBE;
        cpuAddrLow      = 8'hEF;
        memAck          = 1'b0;
        tick();
        cpuCycleRequest = 1'b0;
        m_addr = 16'hBEEF;
        for (int j = 0; j < TO_CYCLES; j++) begin
            checks++;
            if (memReadEnable !== 1'b1 || cpuReady !== 1'b0) begin
                errors++;
                $display("[TB] FAIL timeout_wait cyc=%0d got ren=%b rdy=%b required 1 0",
                         j, memReadEnable, cpuReady);
            end
            memAck      = 1'b0;
            memReadData = 8'($urandom);
            tick();
        end
        m_rdata = TO_DATA;
        m_err   = 1'b1;
        checks++;
        if (cpuReady !== 1'b1 || memReadEnable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_forced got rdy=%b ren=%b required 1 0",
                     cpuReady, memReadEnable);
        end
        checks++;
        if (cpuReadData !== m_rdata || busError !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_data got rd=%h err=%b required rd=%h err=1",
                     cpuReadData, busError, m_rdata);
        end
        idle_cycles(3, "timeout");
        do_access(1'b1, 16'h2222, 8'h00, TO_CYCLES - 1, 8'h5A, "ack_on_timeout");
        idle_cycles(1, "ack_on_timeout");
    endtask
`else
    task automatic test_long_wait;
        do_access(1'b1, 16'hC0DE, 8'h00, 20, 8'h77, "long_wait");
        idle_cycles(1, "long_wait");
    endtask
`endif

    task automatic test_async_reset;
        cpuCycleRequest = 1'b1;
        cpuReadNotWrite = 1'b1;
        cpuAddrHigh     = 8'h55;
        cpuAddrLow      = 8'hAA;
        memAck          = 1'b0;
        tick();
        cpuCycleRequest = 1'b0;
        tick();
        checks++;
        if (memReadEnable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_pre got ren=%b required 1", memReadEnable);
        end
        #2;
        nrst = 1'b0;
        #1;
        checks++;
        if (memReadEnable !== 1'b0 || memWriteEnable !== 1'b0 || memAddress !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL areset_async got ren=%b wen=%b addr=%h required 0 0 0000",
                     memReadEnable, memWriteEnable, memAddress);
        end
        model_reset();
        memAck      = 1'b1;
        memReadData = 8'h99;
        tick();
        checks++;
        if (cpuReady !== 1'b0 || cpuReadData !== 8'h00 || busError !== 1'b0) begin
            errors++;
            $display("[TB] FAIL areset_held got rdy=%b rd=%h err=%b required 0 00 0",
                     cpuReady, cpuReadData, busError);
        end
        memAck = 1'b0;
        nrst   = 1'b1;
        idle_cycles(2, "areset");
        do_access(1'b1, 16'h7E01, 8'h00, 1, 8'hC3, "areset_after");
        idle_cycles(1, "areset_after");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_back_to_back();
        test_random();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/external_bus_interface.md
# external_bus_interface

Registered bus interface unit between the CPU internal dataflow and external memory. It captures the address bytes, write data and direction presented by the core, runs one memory access with a ready/acknowledge handshake and wait-state support, and latches the read data. It returns the latched byte to the core's external data-bus input together with a one-cycle completion strobe that the control logic uses to advance its timing state.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: number of access cycles without acknowledge before a forced completion. Used only with `BUS_TIMEOUT_EN`. Legal range 2..255.
- TIMEOUT_DATA, 8'hFF: read data returned on a forced completion.

Ports:
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous, active-low reset
- cpuAddrLow  in  8  address low byte from the ABL register
- cpuAddrHigh  in  8  address high byte from the ABH register
- cpuWriteData  in  8  write byte from the DOR register
- cpuReadNotWrite  in  1  1 = read cycle, 0 = write cycle
- cpuCycleRequest  in  1  core requests an access; sampled only in IDLE
- cpuReadData  out  8  latched read byte, driven to the dataflow external data-bus read input
- cpuReady  out  1  one-cycle completion strobe
- memAddress  out  16  {high, low} address, registered
- memWriteData  out  8  registered write byte
- memReadEnable  out  1  read strobe, held for the whole access
- memWriteEnable  out  1  write strobe, held for the whole access
- memAck  in  1  memory completes the access
- memReadData  in  8  memory read byte, valid with memAck
- busError  out  1  sticky timeout indicator

## Operation
- FSM states: IDLE and ACCESS.
- **IDLE, with cpuCycleRequest=1 at a clock edge:**
  - Register memAddress={cpuAddrHigh,cpuAddrLow}, memWriteData=cpuWriteData and the direction.
  - Set memReadEnable=cpuReadNotWrite and memWriteEnable=~cpuReadNotWrite.
  - Go to ACCESS.
- **IDLE, with cpuCycleRequest=0:** hold all outputs. memAck is ignored in IDLE.
- **ACCESS:** hold the address, data and enables stable until completion. Exactly one enable is high.
- **ACCESS, with memAck=1 at a clock edge:**
  - Drop both enables.
  - On a read, latch memReadData into cpuReadData. On a write, leave cpuReadData unchanged.
  - Assert cpuReady for the next cycle and go to IDLE.
- cpuCycleRequest during ACCESS is ignored; the core must wait for cpuReady.
- cpuReadData holds the last completed read until the next read completes.
- memAddress and memWriteData hold their last values while idle.

## Timing
- Reset values: cpuReadData=8'h00, cpuReady=0, memAddress=16'h0000, memWriteData=8'h00, both enables 0, busError=0, state IDLE.
- Asserting nrst mid-access drops the enables immediately (asynchronously). No cpuReady is produced.
- Request sampled at edge N:
  - Enables are high from N+1.
  - memAck sampled at edge N+1+k (k wait states, k≥0) gives cpuReady=1 and valid cpuReadData during cycle N+2+k.
  - Minimum turnaround is 2 cycles.
- Back-to-back accesses: the cycle with cpuReady=1 is an IDLE cycle. A request sampled at the end of that cycle is accepted, giving one access every 2 cycles with zero wait states.
- cpuReady is never high for two consecutive cycles.

## Configuration
- **`BUS_TIMEOUT_EN` defined:**
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without memAck.
  - If the counter reaches TIMEOUT_CYCLES-1 with no memAck, the next edge forces completion.
  - Forced completion drops the enables, asserts cpuReady, loads cpuReadData=TIMEOUT_DATA on reads (writes leave it unchanged) and sets busError.
  - busError stays set until reset.
  - If memAck and the timeout occur in the same cycle, memAck wins: normal completion, busError unchanged.
- **`BUS_TIMEOUT_EN` undefined:** no counter is built, ACCESS waits indefinitely for memAck, and busError is tied to 0.

## Test plan
- Reset release with no request → all outputs hold their reset values for 10 cycles; memAck pulses have no effect.
- Read 16'h12F0, memAck in the first ACCESS cycle, memReadData=8'hA5 → read enable high for 1 cycle, memAddress=16'h12F0, cpuReady=1 two cycles after the request with cpuReadData=8'hA5.
- Write 8'h3C to 16'h01FF with 3 wait states → memWriteEnable high for 4 cycles with stable address and data; cpuReady 5 cycles after the request; cpuReadData unchanged.
- Back-to-back: read (ack 8'h11), then a request sampled in the cpuReady cycle for a read (ack 8'h22) → second access starts immediately; two cpuReady pulses 2 cycles apart with data 8'h11 then 8'h22.
- nrst asserted during the second wait cycle of a read → enables drop without a clock edge; no cpuReady; after release the next access works normally.
- With `BUS_TIMEOUT_EN` and TIMEOUT_CYCLES=4, read with no ack → forced completion: cpuReady=1, cpuReadData=8'hFF, busError=1 and stays set. Repeat with memAck arriving on the timeout cycle → normal data, busError unchanged.
